// File: rtl/wait_state_ram.sv
// Single-port word RAM with fixed access latency and per-byte write lanes.
// Optional out-of-range flag on err when RAM_BOUNDS_CHECK_EN is defined.
module wait_state_ram #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic                clck,
    input  logic                reset,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                complete,
    output logic                busy
`ifdef RAM_BOUNDS_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int LANES = DATA_W / 8;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic              accept;
    logic              finish;

    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [LANES-1:0]  lat_be;
    logic [DATA_W-1:0] lat_data;

    logic              in_range;
    logic [IW-1:0]     idx;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    assign in_range = (32'(lat_addr) < DEPTH);
    assign idx      = lat_addr[IW-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;
    assign busy     = (state == S_WAIT);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        finish   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (read || write) begin
                    accept   = 1'b1;
                    cnt_nx   = CW'(LATENCY - 1);
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    finish   = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clck) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            complete <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            complete <= finish;
            if (finish && !lat_wr) begin
                data_out <= rd_word;
            end
        end
    end

`ifdef RAM_BOUNDS_CHECK_EN
    always_ff @(posedge clck) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= finish && !in_range;
        end
    end
`endif

    // Request is frozen at acceptance; a write wins a read/write conflict.
    always_ff @(posedge clck) begin
        if (accept && !reset) begin
            lat_wr   <= write;
            lat_addr <= addr;
            lat_be   <= byte_en;
            lat_data <= data_in;
        end
    end

    always_ff @(posedge clck) begin
        if (!reset && finish && lat_wr && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (lat_be[i]) begin
                    mem[idx][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wait_state_ram.sv
// Bench for wait_state_ram: a full-depth instance and a DEPTH=300 instance
// share stimulus; results are scored against a queue of expected reads.
module tb_wait_state_ram;

    localparam int LAT = 2;

    logic        clck = 1'b0;
    logic        reset;
    logic        read;
    logic        write;
    logic [8:0]  addr;
    logic [3:0]  byte_en;
    logic [31:0] data_in;

    logic [31:0] data_out1;
    logic [31:0] data_out2;
    logic        complete1;
    logic        complete2;
    logic        busy1;
    logic        busy2;
`ifdef RAM_BOUNDS_CHECK_EN
    logic        err1;
    logic        err2;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        er2;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic        er2;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[16];

    wait_state_ram #(
        .DATA_W(32), .ADDR_W(9), .DEPTH(512), .LATENCY(LAT)
    ) dut1 (
        .clck(clck), .reset(reset), .read(read), .write(write),
        .addr(addr), .byte_en(byte_en), .data_in(data_in),
        .data_out(data_out1), .complete(complete1), .busy(busy1)
`ifdef RAM_BOUNDS_CHECK_EN
        , .err(err1)
`endif
    );

    wait_state_ram #(
        .DATA_W(32), .ADDR_W(9), .DEPTH(300), .LATENCY(LAT)
    ) dut2 (
        .clck(clck), .reset(reset), .read(read), .write(write),
        .addr(addr), .byte_en(byte_en), .data_in(data_in),
        .data_out(data_out2), .complete(complete2), .busy(busy2)
`ifdef RAM_BOUNDS_CHECK_EN
        , .err(err2)
`endif
    );

    always #5 clck = ~clck;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        byte_en = '0;
        data_in = '0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [8:0] a,
                         input logic [3:0] be, input logic [31:0] d,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic er2);
        exp_t e;
        read    = rd;
        write   = wr;
        addr    = a;
        byte_en = be;
        data_in = d;
        e.e1    = e1;
        e.e2    = e2;
        e.er2   = er2;
        sbq.push_back(e);
    endtask

    // Wait (bounded) for the completion pulse, then score it.
    task automatic await(input string nm, input int exp_n, input bit clr);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clck);
            n++;
            if (clr && n == 1) begin
                chk({nm, "_busy"}, 32'(busy1), 32'd1);
                idle();
            end
        end while (!complete1 && n < 20);
        chk({nm, "_cycles"}, n, exp_n);
        if (complete1) begin
            chk({nm, "_cpl2"}, 32'(complete2), 32'd1);
            chk({nm, "_busy_lo"}, 32'(busy1), 32'd0);
            if (sbq.size() == 0) begin
                chk({nm, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk({nm, "_d1"}, data_out1, e.e1);
                chk({nm, "_d2"}, data_out2, e.e2);
`ifdef RAM_BOUNDS_CHECK_EN
                chk({nm, "_err1"}, 32'(err1), 32'd0);
                chk({nm, "_err2"}, 32'(err2), 32'(e.er2));
`endif
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1, 0, 9'd0,   4'hF, 32'h0,        32'h0,        32'h0,        0};
        tbl[1]  = '{0, 1, 9'd0,   4'hF, 32'd86,       32'h0,        32'h0,        0};
        tbl[2]  = '{1, 0, 9'd0,   4'h0, 32'h0,        32'd86,       32'd86,       0};
        tbl[3]  = '{0, 1, 9'd511, 4'hF, 32'hAABBCCDD, 32'd86,       32'd86,       1};
        tbl[4]  = '{0, 1, 9'd511, 4'h5, 32'h11223344, 32'd86,       32'd86,       1};
        tbl[5]  = '{1, 0, 9'd511, 4'h0, 32'h0,        32'hAA22CC44, 32'h0,        1};
        tbl[6]  = '{0, 1, 9'd144, 4'hF, 32'hCAFE0144, 32'hAA22CC44, 32'h0,        0};
        tbl[7]  = '{0, 1, 9'd400, 4'hF, 32'hDEADBEEF, 32'hAA22CC44, 32'h0,        1};
        tbl[8]  = '{1, 0, 9'd400, 4'h0, 32'h0,        32'hDEADBEEF, 32'h0,        1};
        tbl[9]  = '{1, 0, 9'd144, 4'h0, 32'h0,        32'hCAFE0144, 32'hCAFE0144, 0};
        tbl[10] = '{0, 1, 9'd5,   4'h0, 32'hFFFFFFFF, 32'hCAFE0144, 32'hCAFE0144, 0};
        tbl[11] = '{1, 0, 9'd5,   4'h0, 32'h0,        32'h0,        32'h0,        0};
        tbl[12] = '{1, 1, 9'd7,   4'hF, 32'h12345678, 32'h0,        32'h0,        0};
        tbl[13] = '{1, 0, 9'd7,   4'h0, 32'h0,        32'h12345678, 32'h12345678, 0};
        tbl[14] = '{0, 1, 9'd7,   4'h8, 32'hEE000000, 32'h12345678, 32'h12345678, 0};
        tbl[15] = '{1, 0, 9'd7,   4'h0, 32'h0,        32'hEE345678, 32'hEE345678, 0};

        idle();
        reset = 1'b1;
        repeat (2) @(negedge clck);
        reset = 1'b0;
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_cpl", 32'(complete1), 32'd0);
        chk("rst_dout", data_out1, 32'h0);
        @(negedge clck);

        // Each vector is issued in the previous completion cycle.
        for (int i = 0; i < 16; i++) begin
            issue(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].be, tbl[i].d,
                  tbl[i].e1, tbl[i].e2, tbl[i].er2);
            await($sformatf("vec%0d", i), LAT + 1, 1'b1);
        end
        @(negedge clck);
        chk("cpl_one_cycle", 32'(complete1), 32'd0);

        // Inputs changed while busy, then held into the completion cycle.
        issue(1, 0, 9'd7, 4'h0, 32'h0, 32'hEE345678, 32'hEE345678, 0);
        @(negedge clck);
        chk("seqA_busy", 32'(busy1), 32'd1);
        read    = 1'b0;
        write   = 1'b1;
        addr    = 9'd9;
        byte_en = 4'hF;
        data_in = 32'h99;
        begin
            exp_t e;
            e.e1  = 32'hEE345678;
            e.e2  = 32'hEE345678;
            e.er2 = 1'b0;
            sbq.push_back(e);
        end
        await("seqA_rd", LAT, 1'b0);
        @(negedge clck);
        chk("seqA_acc_busy", 32'(busy1), 32'd1);
        chk("seqA_acc_cpl", 32'(complete1), 32'd0);
        idle();
        await("seqA_wr", LAT, 1'b0);
        issue(1, 0, 9'd9, 4'h0, 32'h0, 32'h99, 32'h99, 0);
        await("seqA_chk", LAT + 1, 1'b1);

        // Reset while a write is in flight discards it.
        issue(0, 1, 9'd3, 4'hF, 32'd5, 32'h0, 32'h0, 0);
        void'(sbq.pop_back());
        @(negedge clck);
        chk("seqB_busy", 32'(busy1), 32'd1);
        idle();
        reset = 1'b1;
        @(negedge clck);
        reset = 1'b0;
        chk("seqB_busy_lo", 32'(busy1), 32'd0);
        chk("seqB_cpl_lo", 32'(complete1), 32'd0);
        chk("seqB_dout", data_out1, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clck);
            chk($sformatf("seqB_nocpl%0d", k), 32'(complete1), 32'd0);
        end
        issue(1, 0, 9'd3, 4'h0, 32'h0, 32'h0, 32'h0, 0);
        await("seqB_rd", LAT + 1, 1'b1);

        repeat (2) @(negedge clck);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wait_state_ram.md
Name: wait_state_ram

Overview:
- Parametrised successor to the processor's single-port RAM: synchronous word memory with configurable width, depth and access latency.
- Per-byte write enables and a registered request/complete handshake.
- Sits between the memory data/address registers and the datapath control unit; the control unit stalls on busy and advances on complete.
- One clock domain; no internal clock gating. The clock is a free-running clck, not derived from read/write.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 9, address width in bits.
- DEPTH, 512, number of words implemented; must be at most 2**ADDR_W.
- LATENCY, 2, cycles from request acceptance to completion; must be at least 1.

Ports:
- clck  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- read  in  1  read request, sampled only in IDLE.
- write  in  1  write request, sampled only in IDLE.
- addr  in  ADDR_W  word address.
- byte_en  in  DATA_W/8  write lane enables; bit i covers data bits 8i+7..8i; ignored for reads.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data, registered.
- complete  out  1  one-cycle pulse when an access finishes.
- busy  out  1  high while an accepted access is in flight.
- err  out  1  out-of-range flag; present only with RAM_BOUNDS_CHECK_EN.

Behaviour:
- Clock and reset: one clock, clck; reset is synchronous and active-high.
- Reset values: data_out=0, complete=0, busy=0, err=0, state=IDLE, latency counter=0.
- Memory array: not cleared by reset; initialised to all zeros at time zero.
- States: IDLE and WAIT.
- Acceptance: at edge N, in IDLE with read or write high, the block:
  - latches op, addr, byte_en and data_in;
  - loads the counter with LATENCY-1;
  - moves to WAIT.
- Read/write conflict: read and write both high is treated as a write.
- WAIT: counter decrements each edge. At the edge where the counter is 0 (edge N+LATENCY):
  - write: memory updated for enabled lanes only; disabled lanes keep their old value; byte_en=0 performs no update;
  - read: data_out loaded with the latched-address word;
  - complete set for exactly one cycle;
  - state returns to IDLE.
- busy: high for the cycles between edge N and edge N+LATENCY, i.e. exactly LATENCY cycles; low in the complete cycle.
- Back-to-back: a new request sampled at edge N+LATENCY+1 (during the complete cycle) is accepted. Minimum issue interval is LATENCY+1 cycles.
- Ignored inputs: requests while busy are dropped, with no queuing and no error. Input changes during WAIT do not affect the access in flight.
- data_out hold: holds its value until the next read completes; writes never change it.
- Read-after-write to the same address returns the new data.
- Reset mid-access: state returns to IDLE; the pending write is discarded and memory is unchanged; complete is not generated.
- Address range: an address >= DEPTH never writes the array. A read of such an address returns 0.
- Counter width is clog2(LATENCY) bits, minimum 1.

Optional Feature:
- Macro: RAM_BOUNDS_CHECK_EN.
- Defined:
  - err port exists;
  - err pulses together with complete for any access whose latched addr >= DEPTH;
  - write dropped and read returns 0.
- Undefined:
  - err port absent;
  - out-of-range accesses behave identically (write dropped, read returns 0, complete still pulses) with no indication.

Test Plan:
- After reset, read addr 0 with LATENCY=2 -> busy high 2 cycles, then complete 1 cycle with data_out=0.
- Write data_in=86, byte_en=1111 to addr 0, then read addr 0 -> data_out=86; complete pulses once per access, LATENCY+1 cycles apart.
- Write 32'hAABBCCDD to addr 511, then write 32'h11223344 with byte_en=0101, then read addr 511 -> data_out=32'hAA22CC44.
- Assert read at edge N+1 while busy -> ignored; a request held into the complete cycle -> accepted at edge N+LATENCY+1; read and write both high -> write performed.
- Start write of 5 to addr 3, assert reset in WAIT -> no complete, busy=0 next cycle; subsequent read of addr 3 -> 0.
- Configuration DEPTH=300, ADDR_W=9 with RAM_BOUNDS_CHECK_EN: write then read addr 400 -> err pulses with complete on both, data_out=0, addr 144 unchanged.
